// File: rtl/nibble_packer.sv
// nibble_packer: packs a stream of 4-bit nibbles into NIBBLES-wide words,
// first nibble in the LSBs. Output goes through a single valid/ready holding
// register. A flush emits the partial word zero-padded. If the holding
// register is busy, the flush waits and input is blocked until it completes.
module nibble_packer #(
  parameter int NIBBLES = 4,
  parameter int CW      = $clog2(NIBBLES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [3:0]             in_value,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [4*NIBBLES-1:0]   out_data,
  output logic [CW-1:0]          out_count,
  input  logic                   out_ready
);

  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);
  localparam logic [CW-1:0] FULL = CW'(NIBBLES);

  // assembly state
  logic [4*NIBBLES-1:0] r_asm_data;
  logic [CW-1:0]        r_asm_cnt;
  logic                 r_flush_pend;

  // output holding register
  logic                 r_out_valid;
  logic [4*NIBBLES-1:0] r_out_data;
  logic [CW-1:0]        r_out_count;

  logic                 w_slot_free;
  logic                 w_flush_eff;
  logic                 w_in_ready;
  logic                 w_accept;
  logic [CW-1:0]        w_n;
  logic [4*NIBBLES-1:0] w_asm_next;
  logic                 w_full;
  logic                 w_partial;
  logic                 w_load;
  logic                 w_drain;

  // Acceptance, the word as it looks including this cycle's nibble, and
  // the decision whether the holding register loads a new word.
  always_comb begin
    w_slot_free = !r_out_valid || out_ready;
    w_flush_eff = flush || r_flush_pend;
    w_in_ready  = 1'b0;
    // The last nibble of a word may only enter when the word can leave
    // on the same edge, so the assembly buffer never has to hold a full word.
    if (!reset && !r_flush_pend)
      w_in_ready = (r_asm_cnt < LAST) ? 1'b1 : w_slot_free;
    w_accept   = in_valid && w_in_ready;
    w_n        = r_asm_cnt + {{(CW-1){1'b0}}, w_accept};
    w_asm_next = r_asm_data;
    for (int k = 0; k < NIBBLES; k++) begin
      if (w_accept && (r_asm_cnt == CW'(k)))
        w_asm_next[4*k +: 4] = in_value;
    end
    w_full    = w_accept && (r_asm_cnt == LAST);
    // A flush that meets a completing nibble is just a normal full word.
    w_partial = w_flush_eff && (w_n != '0) && (w_n != FULL);
    w_load    = w_full || (w_partial && w_slot_free);
    w_drain   = r_out_valid && out_ready;
  end

  // State update: load a finished/flushed word, else keep assembling.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_asm_data   <= '0;
      r_asm_cnt    <= '0;
      r_flush_pend <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_count  <= '0;
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= w_asm_next;
      r_out_count  <= w_n;
      r_asm_data   <= '0;
      r_asm_cnt    <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_drain)
        r_out_valid <= 1'b0;
      r_asm_data   <= w_asm_next;
      r_asm_cnt    <= w_n;
      // Without a load, a partial flush here means the slot was busy.
      r_flush_pend <= w_partial;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_nibble_packer.sv
// Bench for nibble_packer (NIBBLES=4): directed scenarios with literal
// expectations plus a randomized run against a queue-based reference model.
module tb_nibble_packer;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_value = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  out_count;

  int total = 0;
  int bad   = 0;

  nibble_packer #(.NIBBLES(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_value(in_value),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_data(out_data), .out_count(out_count), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // reference model: pending nibbles as a queue, output register as plain vars
  logic [3:0]  m_q[$];
  bit          m_ov;
  bit          m_pend;
  logic [15:0] m_od;
  logic [2:0]  m_oc;
  bit          obs_ir;
  bit          exp_ir;

  function automatic bit model_ready(bit rst, bit ordy);
    if (rst || m_pend) return 1'b0;
    if (m_q.size() < N - 1) return 1'b1;
    return !m_ov || ordy;
  endfunction

  task automatic model_step(input bit rst, input bit iv, input logic [3:0] v,
                            input bit fl, input bit ordy);
    bit slot_free, emit, drained;
    logic [15:0] w;
    if (rst) begin
      m_q.delete(); m_ov = 0; m_pend = 0; m_od = '0; m_oc = '0;
      return;
    end
    slot_free = !m_ov || ordy;
    drained   = m_ov && ordy;
    if (iv && model_ready(rst, ordy)) m_q.push_back(v);
    emit = 0;
    if (m_q.size() == N) emit = 1;
    else if ((fl || m_pend) && m_q.size() > 0) begin
      if (slot_free) emit = 1; else m_pend = 1;
    end else if (fl || m_pend) m_pend = 0;
    if (emit) begin
      w = '0;
      foreach (m_q[k]) w = w | (16'(m_q[k]) << (4 * k));
      m_od = w; m_oc = 3'(m_q.size()); m_ov = 1; m_pend = 0;
      m_q.delete();
    end else if (drained) m_ov = 0;
  endtask

  // one clock: drive inputs at negedge, sample in_ready mid-cycle,
  // advance the model, then let outputs settle just after posedge
  task automatic cyc(input bit rst, input bit iv, input logic [3:0] v,
                     input bit fl, input bit ordy);
    @(negedge clk);
    reset = rst; in_valid = iv; in_value = v; flush = fl; out_ready = ordy;
    #1;
    obs_ir = in_ready;
    exp_ir = model_ready(rst, ordy);
    model_step(rst, iv, v, fl, ordy);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 1, 4'h5, 0, 1);
    total++;
    if (obs_ir !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", obs_ir); end
    total++;
    if ({out_valid, out_data, out_count} !== 20'h0) begin
      bad++; $display("FAIL reset_outputs got v=%b d=%h c=%0d want all zero", out_valid, out_data, out_count);
    end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 4'(i), 0, 1);
      total++;
      if (obs_ir !== 1'b1) begin bad++; $display("FAIL basic_in_ready nib=%0d got=%b want=1", i, obs_ir); end
    end
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h4321 || out_count !== 3'd4) begin
      bad++; $display("FAIL basic_word got v=%b d=%h c=%0d want v=1 d=4321 c=4", out_valid, out_data, out_count);
    end
    cyc(0, 0, 0, 0, 1);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got v=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 4'(i), 0, 1);
      total++;
      if (obs_ir !== 1'b1) begin bad++; $display("FAIL b2b_stall nib=%0d got in_ready=%b want 1", i, obs_ir); end
      if (i == 3) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h3210 || out_count !== 3'd4) begin
          bad++; $display("FAIL b2b_word0 got v=%b d=%h c=%0d want v=1 d=3210 c=4", out_valid, out_data, out_count);
        end
      end
      if (i == 4) begin
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_single_valid got v=%b want 0", out_valid); end
      end
      if (i == 7) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h7654 || out_count !== 3'd4) begin
          bad++; $display("FAIL b2b_word1 got v=%b d=%h c=%0d want v=1 d=7654 c=4", out_valid, out_data, out_count);
        end
      end
    end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 4; i++) cyc(0, 1, 4'(i), 0, 0);
    for (int i = 5; i <= 7; i++) begin
      cyc(0, 1, 4'(i), 0, 0);
      total++;
      if (obs_ir !== 1'b1) begin bad++; $display("FAIL bp_accept nib=%0d got in_ready=%b want 1", i, obs_ir); end
    end
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h4321 || out_count !== 3'd4) begin
      bad++; $display("FAIL bp_hold got v=%b d=%h c=%0d want v=1 d=4321 c=4", out_valid, out_data, out_count);
    end
    cyc(0, 1, 4'h8, 0, 0);
    total++;
    if (obs_ir !== 1'b0) begin bad++; $display("FAIL bp_block got in_ready=%b want 0", obs_ir); end
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h4321) begin
      bad++; $display("FAIL bp_stable got v=%b d=%h want v=1 d=4321", out_valid, out_data);
    end
    cyc(0, 1, 4'h8, 0, 1);
    total++;
    if (obs_ir !== 1'b1) begin bad++; $display("FAIL bp_release got in_ready=%b want 1", obs_ir); end
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h8765 || out_count !== 3'd4) begin
      bad++; $display("FAIL bp_no_bubble got v=%b d=%h c=%0d want v=1 d=8765 c=4", out_valid, out_data, out_count);
    end
    cyc(0, 0, 0, 0, 1);
    total++;
    if (out_valid !== 1'b0 || out_data !== 16'h8765 || out_count !== 3'd4) begin
      bad++; $display("FAIL bp_drain_hold got v=%b d=%h c=%0d want v=0 d=8765 c=4", out_valid, out_data, out_count);
    end
  endtask

  task automatic test_flush();
    cyc(0, 1, 4'hA, 0, 1);
    cyc(0, 1, 4'hB, 0, 1);
    cyc(0, 0, 0, 1, 1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h00BA || out_count !== 3'd2) begin
      bad++; $display("FAIL flush_partial got v=%b d=%h c=%0d want v=1 d=00BA c=2", out_valid, out_data, out_count);
    end
    cyc(0, 1, 4'hC, 0, 1);
    cyc(0, 0, 0, 1, 1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h000C || out_count !== 3'd1) begin
      bad++; $display("FAIL flush_restart got v=%b d=%h c=%0d want v=1 d=000C c=1", out_valid, out_data, out_count);
    end
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got v=%b want 0", out_valid); end
  endtask

  task automatic test_flush_pend();
    for (int i = 1; i <= 4; i++) cyc(0, 1, 4'(i), 0, 0);
    cyc(0, 1, 4'hC, 0, 0);
    cyc(0, 1, 4'hD, 0, 0);
    cyc(0, 0, 0, 1, 0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h4321) begin
      bad++; $display("FAIL pend_hold got v=%b d=%h want v=1 d=4321", out_valid, out_data);
    end
    cyc(0, 1, 4'hE, 0, 0);
    total++;
    if (obs_ir !== 1'b0) begin bad++; $display("FAIL pend_block got in_ready=%b want 0", obs_ir); end
    cyc(0, 0, 0, 0, 1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h00DC || out_count !== 3'd2) begin
      bad++; $display("FAIL pend_complete got v=%b d=%h c=%0d want v=1 d=00DC c=2", out_valid, out_data, out_count);
    end
    cyc(0, 0, 0, 0, 1);
    for (int i = 1; i <= 3; i++) cyc(0, 1, 4'(i), 0, 1);
    cyc(0, 1, 4'h4, 1, 1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h4321 || out_count !== 3'd4) begin
      bad++; $display("FAIL flush_full got v=%b d=%h c=%0d want v=1 d=4321 c=4", out_valid, out_data, out_count);
    end
    cyc(0, 0, 0, 0, 1);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_full_extra got v=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    cyc(0, 1, 4'h9, 0, 1);
    cyc(0, 1, 4'h8, 0, 1);
    cyc(1, 1, 4'h7, 0, 1);
    total++;
    if (obs_ir !== 1'b0 || {out_valid, out_data, out_count} !== 20'h0) begin
      bad++; $display("FAIL reset_mid got ir=%b v=%b d=%h c=%0d want all zero", obs_ir, out_valid, out_data, out_count);
    end
    for (int i = 1; i <= 4; i++) cyc(0, 1, 4'(i), 0, 1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h4321 || out_count !== 3'd4) begin
      bad++; $display("FAIL reset_mid_word got v=%b d=%h c=%0d want v=1 d=4321 c=4", out_valid, out_data, out_count);
    end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit rst, iv, fl, ordy;
    logic [3:0] v;
    for (int i = 0; i < 800; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      v    = 4'($urandom);
      fl   = ($urandom_range(0, 7) == 0);
      ordy = (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cyc(rst, iv, v, fl, ordy);
      total++;
      if (obs_ir !== exp_ir) begin
        bad++; $display("FAIL rand_in_ready cyc=%0d got=%b want=%b", i, obs_ir, exp_ir);
      end
      total++;
      if (out_valid !== m_ov || out_data !== m_od || out_count !== m_oc) begin
        bad++; $display("FAIL rand_out cyc=%0d got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                        i, out_valid, out_data, out_count, m_ov, m_od, m_oc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_flush_pend();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
